// File: rtl/mux_ser_pkg.sv
// Shared types and lane-order helpers for the mux serializer slice.
// The state encoding and the lane-stepping rules live here so every user agrees on them.
package mux_ser_pkg;

    localparam int NUM_LANES = 4;
    localparam int SEL_W     = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam logic [SEL_W-1:0] LANE_LO = 2'd0;
    localparam logic [SEL_W-1:0] LANE_HI = 2'd3;

    function automatic logic [SEL_W-1:0] first_lane(input logic msb_first);
        if (msb_first) begin
            return LANE_HI;
        end else begin
            return LANE_LO;
        end
    endfunction

    function automatic logic [SEL_W-1:0] last_lane(input logic msb_first);
        if (msb_first) begin
            return LANE_LO;
        end else begin
            return LANE_HI;
        end
    endfunction

    function automatic logic [SEL_W-1:0] next_lane(input logic [SEL_W-1:0] lane,
                                                   input logic             msb_first);
        if (msb_first) begin
            return lane - 2'd1;
        end else begin
            return lane + 2'd1;
        end
    endfunction

endpackage

// File: rtl/mux4x1.sv
// Existing 4:1 mux: Y follows lane I[S].
module mux4x1
    import mux_ser_pkg::*;
(
    input  logic [NUM_LANES-1:0] I,
    input  logic [SEL_W-1:0]     S,
    output logic                 Y
);

    // Lane select.
    always_comb begin
        Y = 1'b0;
        case (S)
            2'd0:    Y = I[0];
            2'd1:    Y = I[1];
            2'd2:    Y = I[2];
            2'd3:    Y = I[3];
            default: Y = 1'b0;
        endcase
    end

endmodule

// File: rtl/mux_serializer.sv
// Handshaked 4-bit word to serial bitstream sequencer driving a 4:1 mux select,
// with a one-entry pending buffer so consecutive frames run without a gap.
module mux_serializer
    import mux_ser_pkg::*;
#(
    parameter int BIT_CYCLES = 1,
    parameter int MSB_FIRST  = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_LANES-1:0] in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [SEL_W-1:0]     sel,
    output logic                 ser_out,
    output logic                 ser_valid,
    output logic                 frame_done
);

    localparam logic       MSB       = (MSB_FIRST != 0);
    localparam logic [7:0] HOLD_LAST = 8'(BIT_CYCLES - 1);

    state_t                 state_r, state_s;
    logic [NUM_LANES-1:0]   act_word_r, act_word_s;
    logic                   act_full_r, act_full_s;
    logic [NUM_LANES-1:0]   pend_word_r, pend_word_s;
    logic                   pend_full_r, pend_full_s;
    logic [SEL_W-1:0]       sel_r, sel_s;
    logic [7:0]             hold_cnt_r, hold_cnt_s;
    logic                   ser_valid_r, ser_valid_s;
    logic                   frame_done_r, frame_done_s;
    logic                   xfer_s;
    logic                   bit_end_s;
    logic                   frame_end_s;
    logic                   direct_load_s;

    assign in_ready   = !pend_full_r && !rst;
    assign xfer_s     = in_valid && in_ready;
    assign sel        = sel_r;
    assign ser_valid  = ser_valid_r;
    assign frame_done = frame_done_r;

    mux4x1 u_mux (
        .I (act_word_r),
        .S (sel_r),
        .Y (ser_out)
    );

    // Next-state, datapath and registered-output lookahead.
    always_comb begin
        state_s       = state_r;
        act_word_s    = act_word_r;
        act_full_s    = act_full_r;
        pend_word_s   = pend_word_r;
        pend_full_s   = pend_full_r;
        sel_s         = sel_r;
        hold_cnt_s    = hold_cnt_r;
        bit_end_s     = 1'b0;
        frame_end_s   = 1'b0;
        direct_load_s = 1'b0;

        case (state_r)
            IDLE: begin
                if (xfer_s) begin
                    act_word_s = in_data;
                    act_full_s = 1'b1;
                    sel_s      = first_lane(MSB);
                    hold_cnt_s = 8'd0;
                    state_s    = SHIFT;
                end else begin
                    act_full_s = 1'b0;
                end
            end
            SHIFT: begin
                bit_end_s   = (hold_cnt_r == HOLD_LAST);
                frame_end_s = bit_end_s && (sel_r == last_lane(MSB));
                if (!bit_end_s) begin
                    hold_cnt_s = hold_cnt_r + 8'd1;
                end else if (!frame_end_s) begin
                    hold_cnt_s = 8'd0;
                    sel_s      = next_lane(sel_r, MSB);
                end else if (pend_full_r) begin
                    hold_cnt_s  = 8'd0;
                    sel_s       = first_lane(MSB);
                    act_word_s  = pend_word_r;
                    pend_full_s = 1'b0;
                end else if (xfer_s) begin
                    hold_cnt_s    = 8'd0;
                    sel_s         = first_lane(MSB);
                    act_word_s    = in_data;
                    direct_load_s = 1'b1;
                end else begin
                    // Frame over with nothing queued: sel keeps its last lane.
                    hold_cnt_s = 8'd0;
                    act_full_s = 1'b0;
                    state_s    = IDLE;
                end

                // Any accepted word not loaded straight into the active slot waits in pending.
                if (xfer_s && !direct_load_s) begin
                    pend_word_s = in_data;
                    pend_full_s = 1'b1;
                end else begin
                    pend_word_s = pend_word_s;
                end
            end
            default: begin
                state_s     = IDLE;
                act_full_s  = 1'b0;
                pend_full_s = 1'b0;
                hold_cnt_s  = 8'd0;
            end
        endcase

        ser_valid_s  = act_full_s;
        frame_done_s = act_full_s && (sel_s == last_lane(MSB)) && (hold_cnt_s == HOLD_LAST);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            act_word_r   <= 4'd0;
            act_full_r   <= 1'b0;
            pend_word_r  <= 4'd0;
            pend_full_r  <= 1'b0;
            sel_r        <= 2'd0;
            hold_cnt_r   <= 8'd0;
            ser_valid_r  <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            state_r      <= state_s;
            act_word_r   <= act_word_s;
            act_full_r   <= act_full_s;
            pend_word_r  <= pend_word_s;
            pend_full_r  <= pend_full_s;
            sel_r        <= sel_s;
            hold_cnt_r   <= hold_cnt_s;
            ser_valid_r  <= ser_valid_s;
            frame_done_r <= frame_done_s;
        end
    end

endmodule

// File: doc/mux_serializer.md
# mux_serializer

Upstream sequencer for the 4:1 mux. It accepts 4-bit parallel words over a valid/ready handshake and drives the mux select `S` from 0 through 3. The mux output is presented as a serial bitstream, LSB first, with a valid qualifier and an end-of-frame pulse. A one-entry pending buffer lets a new word be accepted while the current frame is shifting, so back-to-back frames run with no idle cycle.

## Interface
- `BIT_CYCLES`, default 1: clocks each bit is held on `ser_out`; legal range 1–255.
- `MSB_FIRST`, default 0: 0 scans `S` = 0,1,2,3; 1 scans `S` = 3,2,1,0.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_data`  in  4  parallel word; bit k is mux lane `I[k]`.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  block can accept a word this cycle.
- `sel`  out  2  current mux select, registered; debug/observe.
- `ser_out`  out  1  mux output `Y` for the active word and `sel`.
- `ser_valid`  out  1  `ser_out` carries a frame bit.
- `frame_done`  out  1  one-cycle pulse on the final cycle of a frame's last bit.

## Operation
- Registers:
  - `act_word[3:0]` and `act_full`: the word being shifted.
  - `pend_word[3:0]` and `pend_full`: the one-entry buffer.
  - `sel[1:0]`.
  - `hold_cnt[7:0]`.
  - FSM state.
- FSM states:
  - IDLE: no active word; `ser_valid`=0.
  - SHIFT: `ser_valid`=1, holding bit `sel` for BIT_CYCLES clocks.
- Handshake:
  - A transfer occurs when `in_valid && in_ready` at a rising edge.
  - `in_ready` = `!pend_full && !rst`.
  - The word never changes after it is accepted.
- IDLE + transfer: the word goes directly to `act_word`. `sel` is set to the start lane (0, or 3 if MSB_FIRST), `hold_cnt`=0, and the FSM moves to SHIFT.
- SHIFT + transfer: the word goes to `pend_word` and `pend_full` is set.
- SHIFT bit advance: when `hold_cnt == BIT_CYCLES-1`, `hold_cnt` returns to 0 and `sel` steps +1 (or −1 if MSB_FIRST). Otherwise `hold_cnt` increments.
- End of frame (last lane and `hold_cnt == BIT_CYCLES-1`):
  - `frame_done`=1 that cycle.
  - If `pend_full`: `pend_word` moves to `act_word`, `pend_full` is cleared, `sel` is reset to the start lane, and the FSM stays in SHIFT. There is no gap cycle.
  - Else, if a transfer occurs this same cycle: the incoming word goes straight to `act_word` and the FSM stays in SHIFT.
  - Else: the FSM goes to IDLE.
- Same-cycle transfer and pending-buffer drain: the drained word goes to active and the incoming word goes to pending. `pend_full` stays 1.
- `ser_out` = `act_word[sel]` through the mux sub-module. In IDLE it is don't-care but driven: `sel` holds its last value.
- Reset:
  - `sel`=0, `ser_valid`=0, `frame_done`=0, `act_full`=0, `pend_full`=0, `hold_cnt`=0, state IDLE.
  - `in_ready`=0 while `rst`=1, and 1 on the first cycle after.
  - Reset mid-frame discards both the active and pending words. No `frame_done` is issued.

## Timing
- Latency: a transfer at edge N gives the first bit on `ser_out` with `ser_valid`=1 in cycle N+1.
- Frame length: exactly 4·BIT_CYCLES cycles with `ser_valid`=1.
- `frame_done` coincides with the last `ser_valid` cycle of the frame.
- Back-to-back: with `pend_full`, the next frame's first bit follows the `frame_done` cycle directly. `ser_valid` never drops.
- Throughput: sustained one word per 4·BIT_CYCLES clocks, provided `in_valid` is held high.
- All outputs except `ser_out` and `in_ready` are registered. `ser_out` is a combinational function of registers only; there is no path from `in_*`. `in_ready` is combinational from `pend_full` and `rst`.

## Structure
- Package `mux_ser_pkg` holds:
  - `NUM_LANES`=4 and `SEL_W`=2.
  - The state encoding IDLE=1'b0, SHIFT=1'b1.
  - The lane-order constants.
- Sub-module: the existing `mux4x1` is instantiated as `u_mux`, with ports `I`←`act_word`, `S`←`sel`, `Y`→`ser_out`. The serializer contains no lane-select logic of its own.

## Test plan
1. Reset then single word, BIT_CYCLES=1, `in_data`=4'b1011 → `ser_valid` high for 4 cycles, `ser_out` = 1,1,0,1, `sel` = 0,1,2,3, `frame_done` on the 4th cycle, then IDLE with `ser_valid`=0.
2. MSB_FIRST=1, `in_data`=4'b1000 → `ser_out` = 1,0,0,0 with `sel` = 3,2,1,0.
3. BIT_CYCLES=3, `in_data`=4'b0110 → `ser_out` = 0,0,0,1,1,1,1,1,1,0,0,0 (12 cycles), `frame_done` only on cycle 12.
4. Back-to-back: `in_valid` held with words 4'hA, 4'h5, 4'hF → 12 contiguous `ser_valid` cycles with stream 0101 1010 1111.
   - `in_ready` drops while pending is full and rises in the cycle after each drain.
5. Reset asserted on the 2nd bit of 4'hC with 4'h3 pending → the next cycle shows `ser_valid`=0, `sel`=0, `frame_done`=0, `in_ready`=1. Neither word is ever emitted.
6. Exhaustive: all 16 words with BIT_CYCLES ∈ {1,2}, random `in_valid` gaps → the reassembled serial stream equals the input sequence. No `ser_valid` gap occurs while words are pending.
